// File: rtl/mult_arbiter_if.sv
// ============================================================================
// Module      : mult_arbiter_if
// Description : Requester and multiplier-side signal bundle for mult_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] op_a;
  logic [4*NREQ-1:0] op_b;
  logic [NREQ-1:0]   ack;
  logic [7:0]        result;
  logic              busy;
  logic              err;
  logic              err_clr;
  logic              m_init;
  logic [3:0]        m_a;
  logic [3:0]        m_b;
  logic [7:0]        m_pp;
  logic              m_done;

  modport slave (
    input  req, op_a, op_b, err_clr, m_pp, m_done,
    output ack, result, busy, err, m_init, m_a, m_b
  );

  modport master (
    output req, op_a, op_b, err_clr, m_pp, m_done,
    input  ack, result, busy, err, m_init, m_a, m_b
  );
endinterface

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter/sequencer sharing one 4-bit shift-add
//               multiplier among NREQ requesters, with a WAIT timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int INIT_CYC = 2,
  parameter int TIMEOUT  = 63
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_gnt;
  logic [7:0]      r_cnt;
  logic [NREQ-1:0] r_ack;
  logic [7:0]      r_result;
  logic            r_busy;
  logic            r_err;
  logic            r_init;
  logic [3:0]      r_a;
  logic [3:0]      r_b;

  logic            w_any;
  logic [1:0]      w_sel;
  logic [2:0]      w_sum;

  // Walk from farthest to nearest candidate so the first one after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_sum = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = 3'(r_ptr) + 3'(k);
      if (w_sum >= 3'(NREQ)) begin
        w_sum = w_sum - 3'(NREQ);
      end
      if (bus.req[w_sum[1:0]]) begin
        w_any = 1'b1;
        w_sel = w_sum[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'(NREQ - 1);
      r_gnt    <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_init   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            r_ptr   <= w_sel;
            r_a     <= bus.op_a[{w_sel, 2'b00} +: 4];
            r_b     <= bus.op_b[{w_sel, 2'b00} +: 4];
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_cnt == 8'(INIT_CYC - 1)) begin
            r_init  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (bus.m_done) begin
            r_result <= bus.m_pp;
            r_ack    <= c_ONE << r_gnt;
            r_state  <= S_ACK;
          end else if (r_cnt == 8'(TIMEOUT)) begin
            // Set after the err_clr clear above so a same-cycle timeout wins.
            r_result <= '0;
            r_err    <= 1'b1;
            r_ack    <= c_ONE << r_gnt;
            r_state  <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack    = r_ack;
  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;
  assign bus.m_init = r_init;
  assign bus.m_a    = r_a;
  assign bus.m_b    = r_b;

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Scoreboard bench for mult_arbiter with a behavioural multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(4)) bus ();

  mult_arbiter #(.NREQ(4), .INIT_CYC(2), .TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  // Behavioural multiplier: done three cycles after init falls, unless hung.
  logic hang = 1'b0;
  logic m_done_r;
  logic m_run;
  int   m_cnt;
  assign bus.m_done = m_done_r;
  assign bus.m_pp   = m_done_r ? ({4'b0, bus.m_a} * {4'b0, bus.m_b}) : 8'hAA;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done_r <= 1'b0;
      m_run    <= 1'b0;
      m_cnt    <= 0;
    end else if (bus.m_init) begin
      m_done_r <= 1'b0;
      m_run    <= 1'b1;
      m_cnt    <= 0;
    end else if (m_run) begin
      if (m_cnt == 3 && !hang) begin
        m_done_r <= 1'b1;
        m_run    <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct {
    logic [3:0] ack;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] opq[4][$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic expect_ack(input logic [3:0] a, input logic [7:0] r, input logic e);
    exp_t x;
    x.ack = a; x.res = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic load(input int i);
    logic [7:0] v;
    v = opq[i].pop_front();
    bus.op_a[4*i +: 4] = v[7:4];
    bus.op_b[4*i +: 4] = v[3:0];
    bus.req[i] = 1'b1;
  endtask

  task automatic post(input int i, input logic [3:0] a, input logic [3:0] b);
    opq[i].push_back({a, b});
    if (!bus.req[i]) load(i);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"},    32'(bus.ack),    0);
    check({tag, "_result"}, 32'(bus.result), 0);
    check({tag, "_busy"},   32'(bus.busy),   0);
    check({tag, "_err"},    32'(bus.err),    0);
    check({tag, "_m_init"}, 32'(bus.m_init), 0);
    check({tag, "_m_a"},    32'(bus.m_a),    0);
    check({tag, "_m_b"},    32'(bus.m_b),    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    for (int i = 0; i < 4; i++) opq[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.busy || sb.size() != 0 || (|bus.req)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 0);
    check({tag, "_busy"},  32'(bus.busy),  0);
  endtask

  task automatic wait_init_pulse();
    int n = 0;
    while (!bus.m_init && n < 50) begin @(negedge clk); n++; end
    while (bus.m_init && n < 50) begin @(negedge clk); n++; end
    check("init_seen", 32'(n < 50), 1);
  endtask

  // Requester agent: on ack, reload the next queued operation or drop req.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst_n && bus.ack[i]) begin
          if (opq[i].size() > 0) load(i);
          else bus.req[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (|bus.ack)) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 0);
        end else begin
          e = sb.pop_front();
          check("ack",    32'(bus.ack),    32'(e.ack));
          check("result", 32'(bus.result), 32'(e.res));
          check("err",    32'(bus.err),    32'(e.err));
        end
      end
    end
  end

  // m_init pulse width monitor.
  initial begin
    int icnt = 0;
    forever begin
      @(negedge clk);
      if (bus.m_init) icnt++;
      else if (icnt != 0) begin
        check("init_len", 32'(icnt), 2);
        icnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req = '0; bus.op_a = '0; bus.op_b = '0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single request 0xA * 0xA.
    @(negedge clk);
    expect_ack(4'b0001, 8'h64, 1'b0);
    post(0, 4'hA, 4'hA);
    @(negedge clk);
    check("t1_busy",   32'(bus.busy),   1);
    check("t1_m_init", 32'(bus.m_init), 1);
    check("t1_m_a",    32'(bus.m_a),    32'hA);
    check("t1_m_b",    32'(bus.m_b),    32'hA);
    wait_idle("t1");

    // Simultaneous requests 0 and 1, requester 0 first after reset.
    do_reset();
    expect_ack(4'b0001, 8'h0F, 1'b0);
    expect_ack(4'b0010, 8'hE1, 1'b0);
    post(0, 4'h3, 4'h5);
    post(1, 4'hF, 4'hF);
    n = 0;
    while (!bus.ack[0] && n < 100) begin @(negedge clk); n++; end
    check("t2_ack0_seen", 32'(bus.ack[0]), 1);
    @(negedge clk);
    check("t2_gap_idle", 32'(bus.busy), 0);
    @(negedge clk);
    check("t2_regrant_busy", 32'(bus.busy), 1);
    check("t2_regrant_m_a",  32'(bus.m_a),  32'hF);
    wait_idle("t2");

    // All four requesters continuously busy: grant order 0,1,2,3,0,1,2,3.
    do_reset();
    expect_ack(4'b0001, 8'h02, 1'b0);
    expect_ack(4'b0010, 8'h06, 1'b0);
    expect_ack(4'b0100, 8'h14, 1'b0);
    expect_ack(4'b1000, 8'h2A, 1'b0);
    expect_ack(4'b0001, 8'h3F, 1'b0);
    expect_ack(4'b0010, 8'h40, 1'b0);
    expect_ack(4'b0100, 8'h9C, 1'b0);
    expect_ack(4'b1000, 8'h0F, 1'b0);
    post(0, 4'h1, 4'h2); post(0, 4'h7, 4'h9);
    post(1, 4'h2, 4'h3); post(1, 4'h8, 4'h8);
    post(2, 4'h4, 4'h5); post(2, 4'hC, 4'hD);
    post(3, 4'h6, 4'h7); post(3, 4'hF, 4'h1);
    wait_idle("t3");

    // Hung multiplier: abort 11 cycles after WAIT entry.
    hang = 1'b1;
    expect_ack(4'b0010, 8'h00, 1'b1);
    post(1, 4'h5, 4'h5);
    wait_init_pulse();
    n = 0;
    while (!bus.ack[1] && n < 50) begin @(negedge clk); n++; end
    check("t4_latency", 32'(n), 11);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(bus.err),  1);
    check("t4_idle",       32'(bus.busy), 0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("t4_err_clr", 32'(bus.err), 0);
    wait_idle("t4");

    // Reset asserted in WAIT: outputs clear at once, no ack for the aborted op.
    post(3, 4'h2, 4'h2);
    wait_init_pulse();
    repeat (3) @(negedge clk);
    check("t5_pre_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("t5_async");
    bus.req = '0;
    for (int i = 0; i < 4; i++) opq[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    expect_ack(4'b0100, 8'h00, 1'b0);
    post(2, 4'h0, 4'h9);
    wait_idle("t5a");

    // All requesters after reset: requester 0 wins first.
    do_reset();
    expect_ack(4'b0001, 8'h51, 1'b0);
    expect_ack(4'b0010, 8'h1E, 1'b0);
    expect_ack(4'b0100, 8'h16, 1'b0);
    expect_ack(4'b1000, 8'hB6, 1'b0);
    post(3, 4'hD, 4'hE);
    post(2, 4'hB, 4'h2);
    post(1, 4'hA, 4'h3);
    post(0, 4'h9, 4'h9);
    wait_idle("t5b");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
